// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg: state encoding and default widths for the memory copy engine
package mem_copy_engine_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
    localparam int WORD_BYTES = 2;
    localparam int DEF_DW = 16;
    localparam int DEF_AW = 16;
    localparam int DEF_LW = 16;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src to dst using alternating read/write cycles
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] words_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_op
);
    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d, cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          err_q, err_d, done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                src_d   = src;
                dst_d   = dst;
                rem_d   = len;
                cnt_d   = '0;
                err_d   = src[0] | dst[0];
                done_d  = src[0] | dst[0] | (len == '0);
                state_d = done_d ? S_IDLE : S_READ;
            end
            S_READ: begin
                buf_d   = mem_op;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_d   = src_q + AW'(WORD_BYTES);
                dst_d   = dst_q + AW'(WORD_BYTES);
                rem_d   = rem_q - LW'(1);
                cnt_d   = cnt_q + LW'(1);
                done_d  = rem_q == LW'(1);
                state_d = done_d ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory controls decode from registered state only, so mem_we cannot glitch
    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = cnt_q;
    assign mem_we     = state_q == S_WRITE;
    assign mem_a      = (state_q == S_READ) ? src_q : (state_q == S_WRITE) ? dst_q : '0;
    assign mem_wd     = mem_we ? buf_q : '0;
endmodule
